// File: rtl/multi_digit_adder_display_pkg.sv
// Shared definitions for the multi-digit add/subtract display unit.
//   PH_*       encodings driven on the phase output
//   SEG_BLANK  active-low 7-segment code with every segment off
//   state_t    FSM state type; its encoding is the phase output encoding
package multi_digit_adder_display_pkg;

    localparam logic [1:0] PH_ENTER_A = 2'd0;
    localparam logic [1:0] PH_ENTER_B = 2'd1;
    localparam logic [1:0] PH_SHOW    = 2'd2;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;

    typedef enum logic [1:0] {
        ST_ENTER_A = PH_ENTER_A,
        ST_ENTER_B = PH_ENTER_B,
        ST_SHOW    = PH_SHOW
    } state_t;

endpackage

// File: rtl/multi_digit_adder_display_hex_to_7seg.sv
// Hex nibble to active-low 7-segment decoder.
//   nibble  in   4   value 0..F
//   seg     out  7   bit6..0 = g..a, 0 lights the segment
module hex_to_7seg
    import multi_digit_adder_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/multi_digit_adder_display.sv
// Sequential add/subtract unit with a debounced entry key and hex display.
// Operand A and then operand B are latched from the switches on successive
// key presses; the sum/difference and carry/borrow are then shown.
//   clock      in   1         system clock
//   reset      in   1         asynchronous, active-high
//   k          in   1         raw bouncy key, active-high
//   in         in   W         operand switches
//   mode       in   1         0 = add, 1 = subtract (sampled with B)
//   seg_sum    out  7*NDIG    hex digits, LSD on bits [6:0], active-low
//   seg_carry  out  7         carry/borrow digit, blank while entering
//   phase      out  2         0 = ENTER_A, 1 = ENTER_B, 2 = SHOW
//   done       out  1         high in SHOW
//
// state      | meaning
// ENTER_A    | waiting for a press to latch operand A
// ENTER_B    | A held; next press latches B and computes the result
// SHOW       | result displayed; next press latches a new A
module multi_digit_adder_display
    import multi_digit_adder_display_pkg::*;
#(
    parameter int W         = 8,
    parameter int DB_CYCLES = 1000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  k,
    input  logic [W-1:0]          in,
    input  logic                  mode,
    output logic [7*(W/4)-1:0]    seg_sum,
    output logic [6:0]            seg_carry,
    output logic [1:0]            phase,
    output logic                  done
);

    localparam int NDIG = W / 4;
    localparam int CW   = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    // ---------------- key synchroniser and debounce ----------------
    logic          k_meta;
    logic          k_sync;
    logic          k_filt;
    logic          k_filt_d;
    logic [CW-1:0] db_cnt;
    logic          press;

    // The counter clears on the cycle the filtered level flips, so it never
    // runs past CNT_LAST and cannot wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            k_meta   <= 1'b0;
            k_sync   <= 1'b0;
            k_filt   <= 1'b0;
            k_filt_d <= 1'b0;
            db_cnt   <= '0;
        end else begin
            k_meta   <= k;
            k_sync   <= k_meta;
            k_filt_d <= k_filt;
            if (k_sync == k_filt) begin
                db_cnt <= '0;
            end else if (db_cnt >= CNT_LAST) begin
                k_filt <= k_sync;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign press = k_filt & ~k_filt_d;

    // ---------------- FSM ----------------
    state_t state;
    state_t state_next;
    logic   load_a;
    logic   load_res;
    logic   clear_res;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_ENTER_A;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_a     = 1'b0;
        load_res   = 1'b0;
        clear_res  = 1'b0;
        case (state)
            ST_ENTER_A: begin
                if (press) begin
                    load_a     = 1'b1;
                    state_next = ST_ENTER_B;
                end
            end
            ST_ENTER_B: begin
                if (press) begin
                    load_res   = 1'b1;
                    state_next = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (press) begin
                    load_a     = 1'b1;
                    clear_res  = 1'b1;
                    state_next = ST_ENTER_B;
                end
            end
            default: state_next = ST_ENTER_A;
        endcase
    end

    // ---------------- datapath ----------------
    // B is consumed straight from the switches on the press that latches it;
    // only the computed result and carry need to be held afterwards.
    logic [W-1:0] a_reg;
    logic [W-1:0] result;
    logic         carry;
    logic [W:0]   calc;

    always_comb begin
        if (mode) calc = {(a_reg < in), W'(a_reg - in)};
        else      calc = {1'b0, a_reg} + {1'b0, in};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_reg  <= '0;
            result <= '0;
            carry  <= 1'b0;
        end else begin
            if (load_a) a_reg <= in;
            if (load_res) begin
                result <= calc[W-1:0];
                carry  <= calc[W];
            end else if (clear_res) begin
                result <= '0;
                carry  <= 1'b0;
            end
        end
    end

    // ---------------- display ----------------
    logic         show;
    logic [W-1:0] disp_val;
    logic [6:0]   carry_code;

    assign show     = (state == ST_SHOW);
    assign disp_val = show ? result : in;

    for (genvar g = 0; g < NDIG; g++) begin : g_digit
        hex_to_7seg u_dig (
            .nibble (disp_val[4*g +: 4]),
            .seg    (seg_sum[7*g +: 7])
        );
    end

    hex_to_7seg u_carry (
        .nibble ({3'b000, carry}),
        .seg    (carry_code)
    );

    assign seg_carry = show ? carry_code : SEG_BLANK;
    assign phase     = state;
    assign done      = show;

endmodule

// File: tb/tb_multi_digit_adder_display.sv
module tb_multi_digit_adder_display;

    localparam int W  = 8;
    localparam int DB = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        k     = 1'b0;
    logic [7:0]  sw    = 8'h00;
    logic        mode  = 1'b0;
    logic [13:0] seg_sum;
    logic [6:0]  seg_carry;
    logic [1:0]  phase;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [1:0] m_phase = 2'd0;
    logic [7:0] m_a     = 8'h00;
    logic [7:0] m_res   = 8'h00;
    logic       m_carry = 1'b0;

    multi_digit_adder_display #(.W(W), .DB_CYCLES(DB)) dut (
        .clock     (clock),
        .reset     (reset),
        .k         (k),
        .in        (sw),
        .mode      (mode),
        .seg_sum   (seg_sum),
        .seg_carry (seg_carry),
        .phase     (phase),
        .done      (done)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] hex7(input logic [3:0] d);
        case (d)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [13:0] seg2(input logic [7:0] v);
        return {hex7(v[7:4]), hex7(v[3:0])};
    endfunction

    function automatic logic [13:0] exp_sum();
        return (m_phase == 2'd2) ? seg2(m_res) : seg2(sw);
    endfunction

    function automatic logic [6:0] exp_carry();
        return (m_phase == 2'd2) ? hex7({3'b000, m_carry}) : 7'h7F;
    endfunction

    task automatic model_reset();
        m_phase = 2'd0; m_a = 8'h00; m_res = 8'h00; m_carry = 1'b0;
    endtask

    task automatic model_press();
        int s;
        case (m_phase)
            2'd0: begin m_a = sw; m_phase = 2'd1; end
            2'd1: begin
                if (!mode) begin
                    s = int'(m_a) + int'(sw);
                    m_res = 8'(s % 256); m_carry = (s > 255);
                end else begin
                    s = int'(m_a) - int'(sw) + 256;
                    m_res = 8'(s % 256); m_carry = (m_a < sw);
                end
                m_phase = 2'd2;
            end
            default: begin m_a = sw; m_res = 8'h00; m_carry = 1'b0; m_phase = 2'd1; end
        endcase
    endtask

    // clean press: held well past the filter, then released and allowed to settle
    task automatic press();
        @(negedge clock);
        k = 1'b1;
        repeat (DB + 6) @(negedge clock);
        k = 1'b0;
        model_press();
        repeat (DB + 6) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1; k = 1'b0; mode = 1'b0; sw = 8'h8C;
        model_reset();
        repeat (3) @(negedge clock);
        n_cmp++; if (phase !== 2'd0) begin n_err++; $display("FAIL reset_phase: got %0d want 0", phase); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (seg_carry !== 7'h7F) begin n_err++; $display("FAIL reset_carry: got %b want 1111111", seg_carry); end
        n_cmp++; if (seg_sum !== seg2(8'h8C)) begin n_err++; $display("FAIL reset_sum: got %b want %b", seg_sum, seg2(8'h8C)); end
        reset = 1'b0;
        sw = 8'($urandom);
        repeat (2) @(negedge clock);
        n_cmp++; if (seg_sum !== seg2(sw)) begin n_err++; $display("FAIL reset_live_in: got %b want %b", seg_sum, seg2(sw)); end
    endtask

    task automatic test_add_basic();
        sw = 8'h8C; press();
        n_cmp++; if (phase !== 2'd1) begin n_err++; $display("FAIL add_phase_b: got %0d want 1", phase); end
        n_cmp++; if (seg_carry !== 7'h7F) begin n_err++; $display("FAIL add_carry_blank: got %b want 1111111", seg_carry); end
        sw = 8'h9A; mode = 1'b0; press();
        n_cmp++; if (phase !== 2'd2 || done !== 1'b1) begin n_err++; $display("FAIL add_show: got phase %0d done %b want 2/1", phase, done); end
        n_cmp++; if (seg_sum !== 14'b0100100_0000010) begin n_err++; $display("FAIL add_sum: got %b want 01001000000010", seg_sum); end
        n_cmp++; if (seg_carry !== 7'b1111001) begin n_err++; $display("FAIL add_carry: got %b want 1111001", seg_carry); end
    endtask

    task automatic test_sub_borrow();
        sw = 8'h10; press();
        sw = 8'h20; mode = 1'b1; press();
        n_cmp++; if (seg_sum !== 14'b0001110_1000000) begin n_err++; $display("FAIL sub_sum: got %b want 00011101000000", seg_sum); end
        n_cmp++; if (seg_carry !== 7'b1111001) begin n_err++; $display("FAIL sub_borrow: got %b want 1111001", seg_carry); end
        mode = 1'b0;
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); k = 1'b1;
            repeat (2) @(negedge clock);
            k = 1'b0;
            repeat (1) @(negedge clock);
        end
        repeat (20) @(negedge clock);
        n_cmp++; if (phase !== m_phase) begin n_err++; $display("FAIL glitch_phase: got %0d want %0d", phase, m_phase); end
        n_cmp++; if (seg_sum !== exp_sum()) begin n_err++; $display("FAIL glitch_sum: got %b want %b", seg_sum, exp_sum()); end
    endtask

    task automatic test_hold_latency();
        logic [1:0] old_ph;
        sw = 8'($urandom); mode = 1'b0;
        old_ph = m_phase;
        @(negedge clock);
        k = 1'b1;
        model_press();
        for (int i = 1; i <= 100; i++) begin
            @(negedge clock);
            n_cmp++;
            if (phase !== ((i < DB + 3) ? old_ph : m_phase)) begin
                n_err++;
                $display("FAIL hold_step cycle %0d: got %0d want %0d", i, phase, (i < DB + 3) ? old_ph : m_phase);
            end
        end
        k = 1'b0;
        repeat (DB + 6) @(negedge clock);
        n_cmp++; if (phase !== m_phase) begin n_err++; $display("FAIL hold_release: got %0d want %0d", phase, m_phase); end
    endtask

    task automatic test_reset_mid();
        sw = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            if (m_phase == 2'd1 && m_a == 8'hFF) break;
            press();
        end
        n_cmp++; if (phase !== 2'd1) begin n_err++; $display("FAIL mid_setup: got %0d want 1", phase); end
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        model_reset();
        n_cmp++; if (phase !== 2'd0) begin n_err++; $display("FAIL mid_phase: got %0d want 0", phase); end
        n_cmp++; if (seg_carry !== 7'h7F) begin n_err++; $display("FAIL mid_carry: got %b want 1111111", seg_carry); end
        @(negedge clock);
        reset = 1'b0;
        sw = 8'h01; press();
        sw = 8'h01; mode = 1'b0; press();
        n_cmp++; if (seg_sum !== 14'b1000000_0100100) begin n_err++; $display("FAIL mid_sum: got %b want 10000000100100", seg_sum); end
        n_cmp++; if (seg_carry !== 7'b1000000) begin n_err++; $display("FAIL mid_carry0: got %b want 1000000", seg_carry); end
    endtask

    task automatic test_show_press();
        sw = 8'h33; press();
        n_cmp++; if (phase !== 2'd1) begin n_err++; $display("FAIL show_phase: got %0d want 1", phase); end
        n_cmp++; if (seg_sum !== seg2(8'h33)) begin n_err++; $display("FAIL show_live: got %b want %b", seg_sum, seg2(8'h33)); end
        n_cmp++; if (seg_carry !== 7'h7F) begin n_err++; $display("FAIL show_blank: got %b want 1111111", seg_carry); end
        sw = 8'hCD; mode = 1'b0; press();
        n_cmp++; if (seg_sum !== 14'b1000000_1000000) begin n_err++; $display("FAIL show_zero: got %b want 10000001000000", seg_sum); end
        n_cmp++; if (seg_carry !== 7'b1111001) begin n_err++; $display("FAIL show_carry: got %b want 1111001", seg_carry); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 15; it++) begin
            sw = 8'($urandom); press();
            for (int j = 0; j < 2; j++) begin
                sw = 8'($urandom);
                @(negedge clock);
                n_cmp++; if (phase !== m_phase || seg_sum !== exp_sum() || seg_carry !== exp_carry()) begin
                    n_err++; $display("FAIL rnd_enter it %0d: got %0d %b %b want %0d %b %b", it, phase, seg_sum, seg_carry, m_phase, exp_sum(), exp_carry());
                end
            end
            sw = 8'($urandom); mode = 1'($urandom); press();
            for (int j = 0; j < 2; j++) begin
                sw = 8'($urandom); mode = 1'($urandom);
                @(negedge clock);
                n_cmp++; if (phase !== m_phase || done !== 1'b1 || seg_sum !== exp_sum() || seg_carry !== exp_carry()) begin
                    n_err++; $display("FAIL rnd_show it %0d: got %0d %b %b want %0d %b %b", it, phase, seg_sum, seg_carry, m_phase, exp_sum(), exp_carry());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_sub_borrow();
        test_glitch();
        test_hold_latency();
        test_reset_mid();
        test_show_press();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
